sobel_frame_ctrl: RTL and testbench

SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

---
 rtl/sobel_pkg.sv | 20 ++
 rtl/sobel_pix_counter.sv | 47 ++++
 rtl/sobel_frame_ctrl.sv | 154 +++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel frame controller.
// Holds the FSM state encoding and the line-buffer ring arithmetic.
package sobel_pkg;

  localparam int unsigned NumLineBufs = 3;
  localparam int unsigned LbIdxW      = 2;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StRun,
    StDone
  } frame_state_e;

  // Next index around the three-entry line-buffer ring.
  function automatic logic [LbIdxW-1:0] lb_idx_next(input logic [LbIdxW-1:0] idx);
    return (idx == LbIdxW'(NumLineBufs - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/sobel_pix_counter.sv
// Raster-order row/column counter for the Sobel frame controller.
// Advances on en_i, wraps column into row and row into zero, holds on stall.
module sobel_pix_counter #(
  parameter int unsigned ROWS = 480,
  parameter int unsigned COLS = 640
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic                      en_i,
  output logic [$clog2(COLS)-1:0]   col_o,
  output logic [$clog2(ROWS)-1:0]   row_o,
  output logic                      row_end_o,
  output logic                      frame_end_o
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROWS);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_col_last;
  logic          w_row_last;

  assign w_col_last = (r_col == CW'(COLS - 1));
  assign w_row_last = (r_row == RW'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (en_i) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign col_o       = r_col;
  assign row_o       = r_row;
  assign row_end_o   = w_col_last;
  assign frame_end_o = w_col_last & w_row_last;

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame controller for a 3x3 Sobel window: FSM, line-buffer rotation, window valid.
// Define SOBEL_CTRL_STATUS_EN to add the err_o / frame_cnt_o status ports.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned ROWS = 480,
  parameter int unsigned COLS = 640
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     pix_valid_i,
  output logic                     ready_o,
  output logic                     busy_o,
  output logic [NumLineBufs-1:0]   lb_wr_en_o,
  output logic [LbIdxW-1:0]        lb_rd_sel_o,
  output logic [$clog2(COLS)-1:0]  col_o,
  output logic [$clog2(ROWS)-1:0]  row_o,
  output logic                     win_valid_o,
`ifdef SOBEL_CTRL_STATUS_EN
  output logic                     err_o,
  output logic [15:0]              frame_cnt_o,
`endif
  output logic                     done_o
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROWS);

  frame_state_e      r_state;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic [LbIdxW-1:0] r_wr_idx;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic              r_win;

  logic              w_accept;
  logic [CW-1:0]     w_col;
  logic [RW-1:0]     w_row;
  logic              w_row_end;
  logic              w_frame_end;

  assign w_accept = pix_valid_i & r_ready;

  sobel_pix_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_pix_counter (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (r_state == StDone),
    .en_i        (w_accept),
    .col_o       (w_col),
    .row_o       (w_row),
    .row_end_o   (w_row_end),
    .frame_end_o (w_frame_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wr_idx <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept && w_row_end) begin
        r_wr_idx <= lb_idx_next(r_wr_idx);
      end
      case (r_state)
        StIdle: begin
          if (start_i) begin
            r_state <= StFill;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        // Rows 0 and 1 only prime the line buffers; windows start from row 2.
        StFill: begin
          if (w_accept && w_row_end && (w_row == RW'(1))) begin
            r_state <= StRun;
          end
        end
        StRun: begin
          if (w_accept && w_frame_end) begin
            r_state <= StDone;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        StDone: begin
          r_state  <= StIdle;
          r_wr_idx <= '0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Position and window flag describe the pixel accepted on the previous edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_win <= 1'b0;
    end else begin
      r_win <= w_accept && (w_row >= RW'(2)) && (w_col >= CW'(2));
      if (w_accept) begin
        r_col <= w_col;
        r_row <= w_row;
      end
    end
  end

  assign ready_o     = r_ready;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign col_o       = r_col;
  assign row_o       = r_row;
  assign win_valid_o = r_win;
  assign lb_rd_sel_o = lb_idx_next(r_wr_idx);
  assign lb_wr_en_o  = w_accept ? (NumLineBufs'(1) << r_wr_idx) : '0;

`ifdef SOBEL_CTRL_STATUS_EN
  logic        r_err;
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (start_i && (r_state != StIdle)) begin
        r_err <= 1'b1;
      end else if (pix_valid_i && (r_state == StDone)) begin
        r_err <= 1'b1;
      end else if (start_i && (r_state == StIdle)) begin
        r_err <= 1'b0;
      end
      if (r_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign err_o       = r_err;
  assign frame_cnt_o = r_frame_cnt;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl with a 5x6 frame.
// Directed vector table plus whole-frame sequences (gaps, ignored start, abort).
module tb_sobel_frame_ctrl;

  localparam int unsigned ROWS = 5;
  localparam int unsigned COLS = 6;
  localparam int NPIX = ROWS * COLS;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic       pix_valid_i;
  logic       ready_o;
  logic       busy_o;
  logic [2:0] lb_wr_en_o;
  logic [1:0] lb_rd_sel_o;
  logic [2:0] col_o;
  logic [2:0] row_o;
  logic       win_valid_o;
  logic       done_o;
`ifdef SOBEL_CTRL_STATUS_EN
  logic        err_o;
  logic [15:0] frame_cnt_o;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sobel_frame_ctrl #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .pix_valid_i (pix_valid_i),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .lb_wr_en_o  (lb_wr_en_o),
    .lb_rd_sel_o (lb_rd_sel_o),
    .col_o       (col_o),
    .row_o       (row_o),
    .win_valid_o (win_valid_o),
`ifdef SOBEL_CTRL_STATUS_EN
    .err_o       (err_o),
    .frame_cnt_o (frame_cnt_o),
`endif
    .done_o      (done_o)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  typedef struct {
    logic       rst;
    logic       start;
    logic       pv;
    logic       ready;
    logic       busy;
    logic [2:0] wr;
    logic [1:0] rd;
    logic       win;
    logic       done;
  } vec_t;

  vec_t tv[12];

  // Entry and exit at posedge+1. Drives one frame and checks every cycle.
  task automatic run_frame(input bit toggle, input int extra_start_at, input int abort_at,
                           output int wins, output int dones);
    int acc, cyc, post, pr, pc, r;
    bit pv, prev_acc, exp_done, aborted, exp_win, do_rst;
    acc = 0; cyc = 0; post = 0; pr = 0; pc = 0;
    prev_acc = 0; exp_done = 0; aborted = 0; wins = 0; dones = 0;
    start_i = 1'b1;
    pix_valid_i = 1'b0;
    @(negedge clk);
    chk("start_idle_ready", int'(ready_o), 0);
    @(posedge clk); #1;
    start_i = 1'b0;
    while (post < 3 && cyc < 200) begin
      pv = !aborted && (acc < NPIX) && (!toggle || (cyc % 2 == 0));
      do_rst = pv && (acc == abort_at);
      pix_valid_i = pv;
      start_i = pv && (acc == extra_start_at);
      rst = do_rst;
      @(negedge clk);
`ifdef SOBEL_CTRL_STATUS_EN
      if (cyc == 0) chk("err_cleared_by_start", int'(err_o), 0);
`endif
      if (acc < NPIX && !aborted) begin
        chk("ready_in_frame", int'(ready_o), 1);
        chk("busy_in_frame", int'(busy_o), 1);
      end else begin
        chk("ready_after", int'(ready_o), 0);
        chk("busy_after", int'(busy_o), 0);
      end
      exp_win = prev_acc && pr >= 2 && pc >= 2;
      chk($sformatf("win_valid acc%0d", acc), int'(win_valid_o), int'(exp_win));
      chk($sformatf("done acc%0d", acc), int'(done_o), int'(exp_done));
      if (prev_acc) begin
        chk($sformatf("row_o acc%0d", acc), int'(row_o), pr);
        chk($sformatf("col_o acc%0d", acc), int'(col_o), pc);
      end
      if (aborted) begin
        chk("row_o_after_rst", int'(row_o), 0);
        chk("col_o_after_rst", int'(col_o), 0);
      end
      if (pv) begin
        r = (acc / COLS) % 3;
        chk($sformatf("wr_en acc%0d", acc), int'(lb_wr_en_o), 1 << r);
        chk($sformatf("rd_sel acc%0d", acc), int'(lb_rd_sel_o), (r + 1) % 3);
      end else begin
        chk("wr_en_idle", int'(lb_wr_en_o), 0);
      end
      wins += int'(win_valid_o);
      dones += int'(done_o);
      exp_done = pv && !do_rst && (acc == NPIX - 1);
      prev_acc = pv && !do_rst;
      pr = acc / COLS;
      pc = acc % COLS;
      if (do_rst) aborted = 1;
      if (pv && !do_rst) acc++;
      if (acc == NPIX || aborted) post++;
      @(posedge clk); #1;
      cyc++;
    end
    pix_valid_i = 1'b0;
    start_i = 1'b0;
    rst = 1'b0;
    chk("frame_finished_in_budget", post, 3);
  endtask

  initial begin
    int w, d;
    rst = 1'b1;
    start_i = 1'b0;
    pix_valid_i = 1'b0;

    tv[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 2'd1, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 2'd1, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'd1, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 2'd1, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 2'd1, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 2'd1, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 2'd1, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 2'd1, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd1, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 2'd1, 1'b0, 1'b0};
    tv[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 2'd1, 1'b0, 1'b0};
    tv[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 2'd1, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst ready", int'(ready_o), 0);
    chk("rst busy", int'(busy_o), 0);
    chk("rst wr_en", int'(lb_wr_en_o), 0);
    chk("rst rd_sel", int'(lb_rd_sel_o), 1);
    chk("rst win", int'(win_valid_o), 0);
    chk("rst done", int'(done_o), 0);
    chk("rst row", int'(row_o), 0);
    chk("rst col", int'(col_o), 0);
`ifdef SOBEL_CTRL_STATUS_EN
    chk("rst err", int'(err_o), 0);
    chk("rst frame_cnt", int'(frame_cnt_o), 0);
`endif
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      rst = tv[i].rst;
      start_i = tv[i].start;
      pix_valid_i = tv[i].pv;
      @(negedge clk);
      chk($sformatf("vec%0d ready", i), int'(ready_o), int'(tv[i].ready));
      chk($sformatf("vec%0d busy", i), int'(busy_o), int'(tv[i].busy));
      chk($sformatf("vec%0d wr_en", i), int'(lb_wr_en_o), int'(tv[i].wr));
      chk($sformatf("vec%0d rd_sel", i), int'(lb_rd_sel_o), int'(tv[i].rd));
      chk($sformatf("vec%0d win", i), int'(win_valid_o), int'(tv[i].win));
      chk($sformatf("vec%0d done", i), int'(done_o), int'(tv[i].done));
      if (i == 2) begin
        chk("idle_pv row", int'(row_o), 0);
        chk("idle_pv col", int'(col_o), 0);
      end
      @(posedge clk); #1;
    end

    rst = 1'b1;
    start_i = 1'b0;
    pix_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    run_frame(1'b0, -1, -1, w, d);
    chk("A wins", w, 12);
    chk("A dones", d, 1);
`ifdef SOBEL_CTRL_STATUS_EN
    chk("A err", int'(err_o), 0);
    chk("A frame_cnt", int'(frame_cnt_o), 1);
`endif

    run_frame(1'b1, -1, -1, w, d);
    chk("B gap wins", w, 12);
    chk("B gap dones", d, 1);
`ifdef SOBEL_CTRL_STATUS_EN
    chk("B frame_cnt", int'(frame_cnt_o), 2);
`endif

    run_frame(1'b0, 14, -1, w, d);
    chk("C busy-start wins", w, 12);
    chk("C busy-start dones", d, 1);
`ifdef SOBEL_CTRL_STATUS_EN
    chk("C err", int'(err_o), 1);
    chk("C frame_cnt", int'(frame_cnt_o), 3);
`endif

    run_frame(1'b0, -1, 19, w, d);
    chk("D abort wins", w, 4);
    chk("D abort dones", d, 0);
`ifdef SOBEL_CTRL_STATUS_EN
    chk("D err", int'(err_o), 0);
    chk("D frame_cnt", int'(frame_cnt_o), 0);
`endif

    run_frame(1'b0, -1, -1, w, d);
    chk("E wins", w, 12);
    chk("E dones", d, 1);
`ifdef SOBEL_CTRL_STATUS_EN
    chk("E frame_cnt", int'(frame_cnt_o), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
